imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000; byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 256; largest accepted word count, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-005 SHALL have port rx_valid  input  1  sender offers a byte on rx_data.
REQ-006 SHALL have port rx_data  input  8  offered byte.
REQ-007 SHALL have port rx_ready  output  1  loader can accept a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port mem_addr  output  32  word-aligned byte address for the write.
REQ-010 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_reset  output  1  holds the CPU in reset while high.
REQ-012 SHALL have port done  output  1  program loaded and checksum good.
REQ-013 SHALL have port err  output  1  load aborted.

Function
REQ-014 SHALL accept a byte only on a rising edge where rx_valid=1 and rx_ready=1; rx_data SHALL be ignored otherwise.
REQ-015 SHALL parse the stream as: count high byte, count low byte (16-bit N, big-endian), then N words of 4 bytes each (big-endian, first byte = bits 31:24), then 1 checksum byte.
REQ-016 SHALL use states CNT_HI, CNT_LO, DATA, WRITE, CSUM, DONE, ERR, with every output decoded from registered state and datapath registers.
REQ-017 SHALL drive rx_ready=1 in CNT_HI, CNT_LO, DATA and CSUM, and rx_ready=0 in WRITE, DONE and ERR.
REQ-018 Transitions SHALL be: CNT_HI -> CNT_LO on accept; CNT_LO -> DATA on accept if 1<=N<=MAX_WORDS, else -> ERR; DATA -> WRITE on accepting the 4th byte of a word; WRITE -> DATA if idx+1<N, else -> CSUM; CSUM -> DONE if byte equals the running checksum, else -> ERR; DONE and ERR are held until reset.
REQ-019 In WRITE, mem_we SHALL be 1 for exactly that one cycle, with mem_addr = ADDR_BASE + 4*idx (modulo 2^32) and mem_wdata = the assembled word; idx SHALL then increment.
REQ-020 mem_we SHALL be 0 in every state other than WRITE; mem_addr and mem_wdata are don't-care while mem_we=0.
REQ-021 The write SHALL occur in the cycle immediately after the edge that accepts a word's 4th byte (latency 1).
REQ-022 The running checksum SHALL be the XOR of all bytes accepted before the checksum byte, count bytes included, and SHALL be 8 bits wide.
REQ-023 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; cpu_reset SHALL be 0 only in DONE.
REQ-024 DONE SHALL be reached in the cycle after the edge that accepts a good checksum byte, and cpu_reset SHALL fall in that same cycle.
REQ-025 No memory write SHALL occur after ERR is entered.
REQ-026 The sender SHALL hold rx_valid and rx_data until the byte is accepted; gaps with rx_valid=0 in any receiving state SHALL not change state.

Reset
REQ-027 On any rising edge with reset=1, regardless of state (including mid-load), the loader SHALL go to CNT_HI with idx=0, checksum=0, N=0, byte index=0.
REQ-028 Outputs after the reset edge SHALL be: rx_ready=1, mem_we=0, cpu_reset=1, done=0, err=0.
REQ-029 Memory contents already written SHALL not be cleared by reset.

Verification
REQ-030 Stream 00 02 20 08 00 05 01 09 50 20 57 -> writes (0x0, 0x20080005) and (0x4, 0x01095020), each one cycle; done=1 and cpu_reset=0 one cycle after the 0x57 byte is accepted.
REQ-031 Same stream with checksum 0x58 -> both writes occur, then err=1, done=0, cpu_reset=1; further bytes are never accepted (rx_ready=0).
REQ-032 Count bytes 00 00, and separately 01 01 (257 > MAX_WORDS) -> ERR one cycle after the second count byte; no mem_we pulse.
REQ-033 REQ-030 stream with rx_valid held high through WRITE cycles and random 0-3 cycle idle gaps -> identical writes and result; no byte is dropped or duplicated.
REQ-034 reset pulsed for one cycle after the first word's write, then the full REQ-030 stream is resent -> state restarts at CNT_HI, cpu_reset stays 1 throughout, and the final writes and done match REQ-030.
REQ-035 ADDR_BASE=32'hFFFF_FFFC with N=2 -> write addresses 0xFFFFFFFC then 0x00000000 (wrap-around).

Source files
------------

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: parses a count/words/checksum byte stream,
// writes each 32-bit word to instruction memory and releases the CPU on success.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] CNT_HI = 3'd0;
  localparam logic [2:0] CNT_LO = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] CSUM   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  logic [2:0]  stateReg;
  logic [15:0] countReg;
  logic [15:0] idxReg;
  logic [1:0]  byteIdxReg;
  logic [31:0] wordReg;
  logic [7:0]  csumReg;

  logic        accept;
  logic [15:0] countFull;
  logic [16:0] idxNext;
  logic        countOk;

  assign accept    = rx_valid && rx_ready;
  // The high count byte is parked in countReg[7:0] until the low byte arrives.
  assign countFull = {countReg[7:0], rx_data};
  assign idxNext   = {1'b0, idxReg} + 17'd1;
  assign countOk   = (countFull != 16'd0) && ({1'b0, countFull} <= MAX_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= CNT_HI;
      countReg   <= 16'd0;
      idxReg     <= 16'd0;
      byteIdxReg <= 2'd0;
      wordReg    <= 32'd0;
      csumReg    <= 8'd0;
    end else begin
      case (stateReg)
        CNT_HI: begin
          if (accept) begin
            countReg <= {8'h00, rx_data};
            csumReg  <= csumReg ^ rx_data;
            stateReg <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            countReg <= countFull;
            csumReg  <= csumReg ^ rx_data;
            stateReg <= countOk ? DATA : ERR;
          end
        end
        DATA: begin
          if (accept) begin
            wordReg    <= {wordReg[23:0], rx_data};
            csumReg    <= csumReg ^ rx_data;
            byteIdxReg <= byteIdxReg + 2'd1;
            if (byteIdxReg == 2'd3) begin
              stateReg <= WRITE;
            end
          end
        end
        WRITE: begin
          idxReg   <= idxNext[15:0];
          stateReg <= (idxNext < {1'b0, countReg}) ? DATA : CSUM;
        end
        CSUM: begin
          if (accept) begin
            stateReg <= (rx_data == csumReg) ? DONE : ERR;
          end
        end
        DONE:    stateReg <= DONE;
        ERR:     stateReg <= ERR;
        default: stateReg <= ERR;
      endcase
    end
  end

  always_comb begin
    rx_ready  = (stateReg == CNT_HI) || (stateReg == CNT_LO) ||
                (stateReg == DATA)   || (stateReg == CSUM);
    mem_we    = (stateReg == WRITE);
    mem_addr  = ADDR_BASE + {14'd0, idxReg, 2'b00};
    mem_wdata = wordReg;
    cpu_reset = (stateReg != DONE);
    done      = (stateReg == DONE);
    err       = (stateReg == ERR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-count model of the load protocol checked every
// cycle against two instances (default base and a wrapping base).
module tb_imem_loader;

  localparam int          MAXW      = 256;
  localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rxReadyA, memWeA, cpuResetA, doneA, errA;
  logic [31:0] memAddrA, memWdataA;
  logic        rxReadyB, memWeB, cpuResetB, doneB, errB;
  logic [31:0] memAddrB, memWdataB;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(MAXW)) u_dutA (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rxReadyA), .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
    .cpu_reset(cpuResetA), .done(doneA), .err(errA));

  imem_loader #(.ADDR_BASE(WRAP_BASE), .MAX_WORDS(MAXW)) u_dutB (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rxReadyB), .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
    .cpu_reset(cpuResetB), .done(doneB), .err(errB));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: everything follows from how many bytes have been accepted so far.
  bit          mValid = 0;
  int          mCount, mN, mIdx, mRes;   // mRes: 0 loading, 1 done, 2 error
  logic [7:0]  mXor;
  logic [31:0] mWord;
  bit          mWe, mAcc;

  always @(posedge clk) begin
    int k;
    mAcc = 0;
    if (reset) begin
      mValid = 1; mCount = 0; mN = 0; mIdx = 0; mRes = 0;
      mXor = 8'h00; mWord = 32'h0; mWe = 0;
    end else if (mWe) begin
      mWe = 0;
      mIdx++;
    end else if (mValid && mRes == 0 && rx_valid) begin
      mAcc = 1;
      k = mCount;
      mCount++;
      if (k >= 2 && k == 2 + 4 * mN) begin
        mRes = (rx_data == mXor) ? 1 : 2;
      end else begin
        mXor = mXor ^ rx_data;
        if (k == 0) mN = 256 * int'(rx_data);
        else if (k == 1) begin
          mN = mN + int'(rx_data);
          if (mN < 1 || mN > MAXW) mRes = 2;
        end else begin
          mWord = {mWord[23:0], rx_data};
          if ((k - 2) % 4 == 3) mWe = 1;
        end
      end
    end
  end

  logic [31:0] logAddrA[$], logDataA[$], logAddrB[$];

  always @(negedge clk) begin
    if (mValid) begin
      check("rx_ready_A", {31'd0, rxReadyA}, {31'd0, (mRes == 0 && !mWe)});
      check("mem_we_A", {31'd0, memWeA}, {31'd0, mWe});
      check("done_A", {31'd0, doneA}, {31'd0, mRes == 1});
      check("err_A", {31'd0, errA}, {31'd0, mRes == 2});
      check("cpu_reset_A", {31'd0, cpuResetA}, {31'd0, mRes != 1});
      check("rx_ready_B", {31'd0, rxReadyB}, {31'd0, (mRes == 0 && !mWe)});
      check("mem_we_B", {31'd0, memWeB}, {31'd0, mWe});
      check("done_B", {31'd0, doneB}, {31'd0, mRes == 1});
      check("err_B", {31'd0, errB}, {31'd0, mRes == 2});
      if (mWe) begin
        check("mem_addr_A", memAddrA, 32'(4 * mIdx));
        check("mem_wdata_A", memWdataA, mWord);
        check("mem_addr_B", memAddrB, WRAP_BASE + 32'(4 * mIdx));
        check("mem_wdata_B", memWdataB, mWord);
      end
      if (memWeA) begin
        logAddrA.push_back(memAddrA);
        logDataA.push_back(memWdataA);
      end
      if (memWeB) logAddrB.push_back(memAddrB);
    end
  end

  task automatic doReset(input int n);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int cnt;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data = b;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!mAcc && cnt < 12);
    if (!mAcc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout byte=%h actual=not_accepted required=accepted", b);
    end
  endtask

  task automatic sendSeq(input logic [7:0] s[11], input int n, input bit gaps);
    for (int i = 0; i < n; i++) sendByte(s[i], gaps ? int'($urandom_range(0, 3)) : 0);
    rx_valid = 1'b0;
  endtask

  task automatic clearLogs();
    logAddrA.delete();
    logDataA.delete();
    logAddrB.delete();
  endtask

  logic [7:0] good[11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                           8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
  logic [7:0] bad[11]  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                           8'h01, 8'h09, 8'h50, 8'h20, 8'h58};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    doReset(2);
    @(negedge clk);
    check("lit_reset_ready", {31'd0, rxReadyA}, 32'd1);
    check("lit_reset_cpu_reset", {31'd0, cpuResetA}, 32'd1);
    check("lit_reset_done", {31'd0, doneA}, 32'd0);
    check("lit_reset_err", {31'd0, errA}, 32'd0);

    // Good load, back-to-back bytes
    clearLogs();
    sendSeq(good, 11, 0);
    check("lit_model_xor", {24'd0, mXor}, 32'h57);
    @(negedge clk);
    check("lit_done_latency", {31'd0, doneA}, 32'd1);
    check("lit_cpu_release", {31'd0, cpuResetA}, 32'd0);
    repeat (3) @(negedge clk);
    check("lit_nwrites", logAddrA.size(), 32'd2);
    if (logAddrA.size() == 2 && logAddrB.size() == 2) begin
      check("lit_w0_addr", logAddrA[0], 32'h0);
      check("lit_w0_data", logDataA[0], 32'h2008_0005);
      check("lit_w1_addr", logAddrA[1], 32'h4);
      check("lit_w1_data", logDataA[1], 32'h0109_5020);
      check("lit_wrap_w0", logAddrB[0], 32'hFFFF_FFFC);
      check("lit_wrap_w1", logAddrB[1], 32'h0000_0000);
    end

    // Bad checksum, then bytes offered to a stopped loader
    doReset(1);
    clearLogs();
    sendSeq(bad, 11, 0);
    @(negedge clk);
    check("lit_bad_err", {31'd0, errA}, 32'd1);
    check("lit_bad_cpu_reset", {31'd0, cpuResetA}, 32'd1);
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    repeat (5) begin @(posedge clk); #1; end
    rx_valid = 1'b0;
    check("lit_bad_nwrites", logAddrA.size(), 32'd2);

    // Zero count and oversize count
    doReset(1);
    clearLogs();
    sendByte(8'h00, 0); sendByte(8'h00, 0); rx_valid = 1'b0;
    @(negedge clk);
    check("lit_zero_err", {31'd0, errA}, 32'd1);
    doReset(1);
    sendByte(8'h01, 0); sendByte(8'h01, 1); rx_valid = 1'b0;
    @(negedge clk);
    check("lit_big_err", {31'd0, errA}, 32'd1);
    repeat (2) @(negedge clk);
    check("lit_count_nwrites", logAddrA.size(), 32'd0);

    // Good load with random idle gaps
    doReset(1);
    clearLogs();
    sendSeq(good, 11, 1);
    @(negedge clk);
    check("lit_gap_done", {31'd0, doneA}, 32'd1);
    check("lit_gap_nwrites", logDataA.size(), 32'd2);
    if (logDataA.size() == 2) check("lit_gap_w1", logDataA[1], 32'h0109_5020);

    // Reset mid-load after first word, then full resend
    doReset(1);
    clearLogs();
    sendSeq(good, 6, 0);
    @(posedge clk); #1;
    doReset(1);
    sendSeq(good, 11, 1);
    @(negedge clk);
    check("lit_restart_done", {31'd0, doneA}, 32'd1);
    check("lit_restart_nwrites", logDataA.size(), 32'd3);
    if (logDataA.size() == 3) begin
      check("lit_restart_w1_addr", logAddrA[1], 32'h0);
      check("lit_restart_w2_data", logDataA[2], 32'h0109_5020);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
